// File: rtl/adder_pipe_if.sv
// adder_pipe_if: operand/result stream bundle for adder_pipe.
// Signals: in_valid/in_ready/a/b/cin/sub[/sat] in; out_valid/out_ready/y/cout/ovf out.
interface adder_pipe_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
    logic             sub;
`ifdef ADDER_PIPE_SAT_EN
    logic             sat;
`endif
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] y;
    logic             cout;
    logic             ovf;

`ifdef ADDER_PIPE_SAT_EN
    modport master (
        output in_valid, a, b, cin, sub, sat, out_ready,
        input  in_ready, out_valid, y, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, sat, out_ready,
        output in_ready, out_valid, y, cout, ovf
    );
`else
    modport master (
        output in_valid, a, b, cin, sub, out_ready,
        input  in_ready, out_valid, y, cout, ovf
    );
    modport slave (
        input  in_valid, a, b, cin, sub, out_ready,
        output in_ready, out_valid, y, cout, ovf
    );
`endif
endinterface

// File: rtl/adder_pipe.sv
// adder_pipe: WIDTH-bit add/sub, carry chain split into SLICE-bit register stages.
// Ports: clk, rst_n (async low), bus (adder_pipe_if.slave); ADDER_PIPE_SAT_EN adds sat.
module adder_pipe #(
    parameter int WIDTH = 8,
    parameter int SLICE = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    adder_pipe_if.slave  bus
);
    localparam int STAGES = WIDTH / SLICE;
    localparam int L      = STAGES - 1;

    logic [STAGES-1:0][WIDTH-1:0] a_q, a_d;
    logic [STAGES-1:0][WIDTH-1:0] b_q, b_d;
    logic [STAGES-1:0][WIDTH-1:0] s_q, s_d;
    logic [STAGES-1:0]            c_q, c_d;
    logic [STAGES-1:0]            v_q, v_d;
    logic                         ovf_q, ovf_d;
`ifdef ADDER_PIPE_SAT_EN
    logic [STAGES-1:0]            sat_q, sat_d;
`endif

    logic             advance;
    logic [WIDTH-1:0] ai, bi, si;
    logic             ci, vi, cmsb;
    logic [SLICE:0]   part;
    int               kp;
`ifdef ADDER_PIPE_SAT_EN
    logic             sati;
`endif

    assign bus.in_ready  = bus.out_ready || !v_q[L];
    assign advance       = bus.in_ready;
    assign bus.out_valid = v_q[L];
    assign bus.y         = s_q[L];
    assign bus.cout      = c_q[L];
    assign bus.ovf       = ovf_q;

    always_comb begin
        a_d   = a_q;
        b_d   = b_q;
        s_d   = s_q;
        c_d   = c_q;
        v_d   = v_q;
        ovf_d = ovf_q;
        ai    = '0;
        bi    = '0;
        si    = '0;
        ci    = 1'b0;
        vi    = 1'b0;
        part  = '0;
        kp    = 0;
        cmsb  = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
        sat_d = sat_q;
        sati  = 1'b0;
`endif
        for (int k = 0; k < STAGES; k++) begin
            kp = (k > 0) ? k - 1 : 0;
            if (k == 0) begin
                // B is inverted once here; later stages see B' only
                ai = bus.a;
                bi = bus.sub ? ~bus.b : bus.b;
                si = '0;
                ci = bus.cin;
                vi = bus.in_valid;
`ifdef ADDER_PIPE_SAT_EN
                sati = bus.sat;
`endif
            end else begin
                ai = a_q[kp];
                bi = b_q[kp];
                si = s_q[kp];
                ci = c_q[kp];
                vi = v_q[kp];
`ifdef ADDER_PIPE_SAT_EN
                sati = sat_q[kp];
`endif
            end
            part = {1'b0, ai[k*SLICE +: SLICE]}
                 + {1'b0, bi[k*SLICE +: SLICE]}
                 + {{SLICE{1'b0}}, ci};
            a_d[k] = ai;
            b_d[k] = bi;
            s_d[k] = si;
            s_d[k][k*SLICE +: SLICE] = part[SLICE-1:0];
            c_d[k] = part[SLICE];
            v_d[k] = vi;
`ifdef ADDER_PIPE_SAT_EN
            sat_d[k] = sati;
`endif
        end
        // carry into the MSB recovered from the MSB sum bit
        cmsb  = a_d[L][WIDTH-1] ^ b_d[L][WIDTH-1] ^ s_d[L][WIDTH-1];
        ovf_d = cmsb ^ c_d[L];
`ifdef ADDER_PIPE_SAT_EN
        // on overflow both operands share the sign, so A's MSB is the true sign
        if (sat_d[L] && ovf_d) begin
            s_d[L] = a_d[L][WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                     : {1'b0, {(WIDTH-1){1'b1}}};
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_q   <= '0;
            b_q   <= '0;
            s_q   <= '0;
            c_q   <= '0;
            v_q   <= '0;
            ovf_q <= 1'b0;
`ifdef ADDER_PIPE_SAT_EN
            sat_q <= '0;
`endif
        end else if (advance) begin
            a_q   <= a_d;
            b_q   <= b_d;
            s_q   <= s_d;
            c_q   <= c_d;
            v_q   <= v_d;
            ovf_q <= ovf_d;
`ifdef ADDER_PIPE_SAT_EN
            sat_q <= sat_d;
`endif
        end
    end

    // finished operand slices and the last stage's copies are never read
    logic unused_bits;
`ifdef ADDER_PIPE_SAT_EN
    assign unused_bits = ^{a_q, b_q, sat_q};
`else
    assign unused_bits = ^{a_q, b_q};
`endif
endmodule

// File: tb/tb_adder_pipe.sv
// tb_adder_pipe: directed + random scoreboard bench for adder_pipe.
// WIDTH=8, SLICE=4, latency 2.
module tb_adder_pipe;
    localparam int W = 8;
    localparam int STAGES = 2;

    typedef struct {
        logic [W-1:0] y;
        logic         c;
        logic         o;
        int           t;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    int   nchk = 0;
    int   nerr = 0;
    int   cyc = 0;
    int   nemit = 0;
    bit   lat_chk = 1'b1;
    bit   acc;
    exp_t nxt;
    exp_t sb[$];
    logic [W-1:0] yhold;
    int   e0;

    adder_pipe_if #(.WIDTH(W)) bus ();

    adder_pipe #(.WIDTH(W), .SLICE(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(logic [W-1:0] a, logic [W-1:0] b,
                                   logic cin, logic sub, logic sat);
        exp_t r;
        logic [W-1:0] bb;
        logic [W:0]   full;
        bb   = sub ? ~b : b;
        full = {1'b0, a} + {1'b0, bb} + {{W{1'b0}}, cin};
        r.y  = full[W-1:0];
        r.c  = full[W];
        r.o  = (a[W-1] == bb[W-1]) && (full[W-1] != a[W-1]);
`ifdef ADDER_PIPE_SAT_EN
        if (sat && r.o) r.y = a[W-1] ? 8'h80 : 8'h7F;
`else
        if (sat) r.y = r.y;
`endif
        r.t = 0;
        return r;
    endfunction

    task automatic drive(logic [W-1:0] a, logic [W-1:0] b,
                         logic cin, logic sub, logic sat);
        bus.in_valid = 1'b1;
        bus.a   = a;
        bus.b   = b;
        bus.cin = cin;
        bus.sub = sub;
`ifdef ADDER_PIPE_SAT_EN
        bus.sat = sat;
`endif
        nxt = model(a, b, cin, sub, sat);
    endtask

    task automatic cycle(output bit accepted);
        exp_t e;
        #4;
        accepted = bus.in_valid && bus.in_ready;
        if (bus.out_valid && bus.out_ready) begin
            nemit++;
            nchk++;
            assert (sb.size() != 0) else begin
                nerr++;
                $error("FAIL extra_beat obs=y%0h exp=no_beat", bus.y);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                check("y", bus.y, e.y);
                check("cout", bus.cout, e.c);
                check("ovf", bus.ovf, e.o);
                if (lat_chk) check("latency", cyc - e.t, STAGES);
            end
        end
        if (accepted) begin
            e = nxt;
            e.t = cyc;
            sb.push_back(e);
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic send_exp(logic [W-1:0] a, logic [W-1:0] b, logic cin,
                            logic sub, logic sat, logic [W-1:0] y,
                            logic c, logic o);
        bit ok;
        drive(a, b, cin, sub, sat);
        nxt.y = y;
        nxt.c = c;
        nxt.o = o;
        cycle(ok);
        check("accept", ok, 1);
        bus.in_valid = 1'b0;
    endtask

    task automatic drain(int max);
        bit ok;
        bus.in_valid = 1'b0;
        for (int i = 0; i < max && sb.size() != 0; i++) cycle(ok);
        check("drain_empty", sb.size(), 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        bus.a   = '0;
        bus.b   = '0;
        bus.cin = 1'b0;
        bus.sub = 1'b0;
`ifdef ADDER_PIPE_SAT_EN
        bus.sat = 1'b0;
`endif
        #3;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_y", bus.y, 0);
        check("rst_cout", bus.cout, 0);
        check("rst_ovf", bus.ovf, 0);
        check("rst_in_ready", bus.in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        send_exp(8'hAA, 8'h8A, 1, 0, 0, 8'h35, 1, 1);
        drain(6);
        send_exp(8'hAA, 8'h8A, 0, 0, 0, 8'h34, 1, 1);
        drain(6);
        send_exp(8'h10, 8'h20, 1, 1, 0, 8'hF0, 0, 0);
        drain(6);
        send_exp(8'hFF, 8'hFF, 1, 0, 0, 8'hFF, 1, 0);
        drain(6);

        e0 = nemit;
        for (int i = 0; i < 16; i++) begin
            drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), 0);
            cycle(acc);
            check("b2b_accept", acc, 1);
        end
        check("b2b_rate", nemit - e0, 14);
        drain(6);
        check("b2b_total", nemit - e0, 16);

        lat_chk = 1'b0;
        e0 = nemit;
        bus.out_ready = 1'b0;
        drive(8'h01, 8'h02, 0, 0, 0);
        cycle(acc);
        check("st_acc0", acc, 1);
        drive(8'h33, 8'h44, 1, 0, 0);
        cycle(acc);
        check("st_acc1", acc, 1);
        drive(8'h90, 8'h0F, 0, 1, 0);
        check("st_ready_low", bus.in_ready, 0);
        yhold = bus.y;
        check("st_y_first", yhold, 8'h03);
        cycle(acc);
        check("st_acc2", acc, 0);
        cycle(acc);
        check("st_hold_ready", bus.in_ready, 0);
        check("st_hold_valid", bus.out_valid, 1);
        check("st_hold_y", bus.y, yhold);
        bus.out_ready = 1'b1;
        for (int i = 0; i < 10 && !acc; i++) cycle(acc);
        check("st_acc2_late", acc, 1);
        drain(8);
        check("st_count", nemit - e0, 3);
        lat_chk = 1'b1;

        drive(8'h11, 8'h22, 0, 0, 0);
        cycle(acc);
        drive(8'h55, 8'h66, 0, 0, 0);
        cycle(acc);
        rst_n = 1'b0;
        #1;
        check("arst_out_valid", bus.out_valid, 0);
        check("arst_y", bus.y, 0);
        check("arst_in_ready", bus.in_ready, 1);
        sb.delete();
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cycle(acc);
            check("post_rst_idle", bus.out_valid, 0);
        end

`ifdef ADDER_PIPE_SAT_EN
        send_exp(8'h7F, 8'h01, 0, 0, 1, 8'h7F, 0, 1);
        drain(6);
        send_exp(8'h80, 8'hFF, 0, 0, 1, 8'h80, 1, 1);
        drain(6);
        send_exp(8'h7F, 8'h01, 0, 0, 0, 8'h80, 0, 1);
        drain(6);
        send_exp(8'h80, 8'hFF, 0, 0, 0, 8'h7F, 1, 1);
        drain(6);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
